// File: rtl/apb_master_bridge_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB master bridge and its peripheral
// subsystem.
//   apb_state_t : bridge FSM state encoding (IDLE, SETUP, ACCESS, RESP)
//   apb_rsp_t   : response record returned to the requester
//   MUL_* / PWM_BASE : address map of the multiplier and PWM slaves
// ---------------------------------------------------------------------------
package apb_pkg;

    // Data width of the peripheral subsystem bus; the response record is
    // sized to it, so a bridge instance must use DATA_WIDTH <= APB_DATA_W.
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // Peripheral address map
    localparam logic [31:0] MUL_A     = 32'h0000_0FF0;
    localparam logic [31:0] MUL_B     = 32'h0000_02C4;
    localparam logic [31:0] MUL_START = 32'h0000_000C;
    localparam logic [31:0] MUL_RES   = 32'h0000_0008;
    localparam logic [31:0] PWM_BASE  = 32'h0000_1000;

endpackage

// File: rtl/apb_master_bridge_timeout_counter.sv
// ---------------------------------------------------------------------------
// apb_timeout_counter
// Counts ACCESS cycles spent waiting for PREADY and flags the last allowed
// cycle.
//   clk    : clock
//   rst    : synchronous active-high reset
//   i_clr  : clear the count (takes priority over i_en)
//   i_en   : advance the count by one
//   o_tc   : terminal count, high while count == TIMEOUT_CYCLES-1;
//            never asserted when TIMEOUT_CYCLES == 0
// ---------------------------------------------------------------------------
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_CNT_WIDTH   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int LP_LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TO_CNT_WIDTH-1:0] LP_LAST = TO_CNT_WIDTH'(LP_LAST_INT);

    logic [TO_CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Single-beat APB initiator. Accepts one command on a valid/ready request
// port, runs one APB SETUP/ACCESS transfer, and returns read data plus error
// and timeout status on a valid/ready response port.
//   PCLK, PRESET                : clock, synchronous active-high reset
//   cmd_valid/cmd_ready         : request handshake
//   cmd_write/cmd_addr/cmd_wdata: request fields
//   rsp_valid/rsp_ready         : response handshake
//   rsp_rdata/rsp_err/rsp_timeout : response fields
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA : APB request outputs
//   PREADY/PRDATA/PSLAVEERR     : APB slave inputs
// ---------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_CNT_WIDTH   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // request port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLAVEERR
);

    apb_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_rsp_valid;
    apb_rsp_t              r_rsp;

    logic w_to_clr;
    logic w_to_en;
    logic w_to_tc;

    // The counter sits at zero outside ACCESS, so it starts every transfer
    // fresh; it only advances on cycles where the slave is still stalling.
    assign w_to_clr = (r_state != ACCESS);
    assign w_to_en  = (r_state == ACCESS) && !PREADY;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_CNT_WIDTH   (TO_CNT_WIDTH)
    ) u_timeout (
        .clk   (PCLK),
        .rst   (PRESET),
        .i_clr (w_to_clr),
        .i_en  (w_to_en),
        .o_tc  (w_to_tc)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_paddr  <= cmd_addr;
                        r_pwrite <= cmd_write;
                        r_pwdata <= cmd_write ? cmd_wdata : '0;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // A slave completing on the terminal cycle beats the
                    // timeout, hence PREADY is tested first.
                    if (PREADY) begin
                        r_rsp.rdata   <= r_pwrite ? '0 : APB_DATA_W'(PRDATA);
                        r_rsp.err     <= PSLAVEERR;
                        r_rsp.timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (w_to_tc) begin
                        r_rsp.rdata   <= '0;
                        r_rsp.err     <= 1'b1;
                        r_rsp.timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp.rdata[DATA_WIDTH-1:0];
    assign rsp_err     = r_rsp.err;
    assign rsp_timeout = r_rsp.timeout;
    assign PADDR       = r_paddr;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PWDATA      = r_pwdata;

endmodule
